// File: rtl/store_unit.sv
// Store unit: places byte/halfword/word stores onto a word-wide write port, splitting lane-crossing stores into two beats.
// Latency: beats start the cycle after acceptance and done follows the last beat; beat outputs stay stable while mem_ready is low.
module store_unit #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, ERR} state_t;

  // Both beats are pre-shifted at acceptance: the low word feeds beat 1, the high word beat 2.
  typedef struct packed {
    logic [31:0] word_addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        two_beat;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q, req_nxt;
  logic        done_q;
  logic        final_hs;
  logic [1:0]  off;
  logic [2:0]  nbytes;
  logic [2:0]  span;
  logic [7:0]  mask;
  logic [31:0] dmask;
  logic        illegal;
  logic        reject;

  always_comb begin
    off     = req_addr[1:0];
    illegal = 1'b0;
    nbytes  = 3'd1;
    mask    = 8'h01;
    dmask   = 32'h0000_00ff;
    case (req_size)
      2'b00: ;
      2'b01: begin
        nbytes = 3'd2;
        mask   = 8'h03;
        dmask  = 32'h0000_ffff;
      end
      2'b10: begin
        nbytes = 3'd4;
        mask   = 8'h0f;
        dmask  = 32'hffff_ffff;
      end
      default: illegal = 1'b1;
    endcase
    span              = {1'b0, off} + nbytes;
    req_nxt.word_addr = {req_addr[31:2], 2'b00};
    req_nxt.wdata     = {32'd0, req_data & dmask} << {off, 3'b000};
    req_nxt.be        = mask << off;
    req_nxt.two_beat  = (span > 3'd4);
    reject            = illegal | (req_nxt.two_beat & !SPLIT_EN);
  end

  always_comb begin
    state_nxt = state;
    final_hs  = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_be    = 4'd0;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = reject ? ERR : BEAT1;
      end
      BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = req_q.word_addr;
        mem_wdata = req_q.wdata[31:0];
        mem_be    = req_q.be[3:0];
        if (mem_ready) begin
          if (req_q.two_beat) begin
            state_nxt = BEAT2;
          end else begin
            state_nxt = IDLE;
            final_hs  = 1'b1;
          end
        end
      end
      BEAT2: begin
        mem_valid = 1'b1;
        mem_addr  = req_q.word_addr + 32'd4;
        mem_wdata = req_q.wdata[63:32];
        mem_be    = req_q.be[7:4];
        if (mem_ready) begin
          state_nxt = IDLE;
          final_hs  = 1'b1;
        end
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign err       = (state == ERR);
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      req_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= final_hs;
      if (state == IDLE && req_valid) req_q <= req_nxt;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Randomized and directed bench for store_unit; runs SPLIT_EN=1 and SPLIT_EN=0 instances side by side against a byte-level model.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        reset, req_valid, mem_ready;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_size;

  logic        rdy   [2];
  logic        mvld  [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd   [2];
  logic [3:0]  mbe   [2];
  logic        dn    [2];
  logic        er    [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_unit #(.SPLIT_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(mvld[0]), .mem_ready(mem_ready), .mem_addr(maddr[0]),
    .mem_wdata(mwd[0]), .mem_be(mbe[0]), .done(dn[0]), .err(er[0])
  );

  store_unit #(.SPLIT_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(mvld[1]), .mem_ready(mem_ready), .mem_addr(maddr[1]),
    .mem_wdata(mwd[1]), .mem_be(mbe[1]), .done(dn[1]), .err(er[1])
  );

  // Model: per instance, the list of pending write beats built byte by byte, plus pulse flags.
  int          nb [2];
  int          bi [2];
  logic [31:0] ba [2][2];
  logic [31:0] bw [2][2];
  logic [3:0]  bb [2][2];
  bit          merr  [2];
  bit          mdone [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic accept(input int k);
    int off, n, pos, w;
    off = int'(req_addr[1:0]);
    n   = (req_size == 2'b00) ? 1 : (req_size == 2'b01) ? 2 : (req_size == 2'b10) ? 4 : 0;
    if (n == 0 || (off + n > 4 && k == 0)) begin
      merr[k] = 1'b1;
    end else begin
      for (int j = 0; j < 2; j++) begin
        ba[k][j] = {req_addr[31:2], 2'b00} + 32'(4 * j);
        bw[k][j] = 32'd0;
        bb[k][j] = 4'd0;
      end
      for (int i = 0; i < n; i++) begin
        pos = off + i;
        w   = pos / 4;
        bw[k][w][8*(pos%4) +: 8] = req_data[8*i +: 8];
        bb[k][w][pos%4]          = 1'b1;
      end
      bi[k] = 0;
      nb[k] = (off + n > 4) ? 2 : 1;
    end
  endtask

  task automatic model_edge();
    bit was_err;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        nb[k] = 0; bi[k] = 0; merr[k] = 1'b0; mdone[k] = 1'b0;
      end else begin
        was_err  = merr[k];
        merr[k]  = 1'b0;
        mdone[k] = 1'b0;
        if (bi[k] < nb[k]) begin
          if (mem_ready) begin
            bi[k]++;
            if (bi[k] == nb[k]) mdone[k] = 1'b1;
          end
        end else if (!was_err && req_valid) begin
          accept(k);
        end
      end
    end
  endtask

  task automatic compare();
    bit act;
    for (int k = 0; k < 2; k++) begin
      act = (bi[k] < nb[k]);
      chk($sformatf("dut%0d.req_ready", k), 32'(rdy[k]), 32'(!act && !merr[k]));
      chk($sformatf("dut%0d.mem_valid", k), 32'(mvld[k]), 32'(act));
      chk($sformatf("dut%0d.done", k), 32'(dn[k]), 32'(mdone[k]));
      chk($sformatf("dut%0d.err", k), 32'(er[k]), 32'(merr[k]));
      if (act) begin
        chk($sformatf("dut%0d.mem_addr", k), maddr[k], ba[k][bi[k]]);
        chk($sformatf("dut%0d.mem_be", k), 32'(mbe[k]), 32'(bb[k][bi[k]]));
        chk($sformatf("dut%0d.mem_wdata", k), mwd[k] & lanes(bb[k][bi[k]]), bw[k][bi[k]]);
      end else begin
        chk($sformatf("dut%0d.idle_addr", k), maddr[k], 32'd0);
        chk($sformatf("dut%0d.idle_wdata", k), mwd[k], 32'd0);
        chk($sformatf("dut%0d.idle_be", k), 32'(mbe[k]), 32'd0);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    mem_ready = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    int done_cnt;
    reset = 1'b1; req_valid = 1'b0; mem_ready = 1'b0;
    req_addr = 32'd0; req_data = 32'd0; req_size = 2'b00;
    step();
    step();
    chk("reset.req_ready", 32'(rdy[1]), 32'd1);
    chk("reset.mem_valid", 32'(mvld[1]), 32'd0);
    chk("reset.done", 32'(dn[1]), 32'd0);
    reset = 1'b0;
    step();

    // Byte store into lane 3.
    mem_ready = 1'b1;
    send(32'h13, 32'hAABBCCDD, 2'b00);
    chk("byte.addr", maddr[1], 32'h10);
    chk("byte.wdata", mwd[1], 32'hDD000000);
    chk("byte.be", 32'(mbe[1]), 32'h8);
    step();
    chk("byte.done", 32'(dn[1]), 32'd1);
    drain();

    // Halfword into the upper lanes.
    send(32'h102, 32'h12345678, 2'b01);
    chk("half.addr", maddr[1], 32'h100);
    chk("half.wdata", mwd[1], 32'h56780000);
    chk("half.be", 32'(mbe[1]), 32'hC);
    drain();

    // Misaligned word: split on dut1, rejected on dut0.
    send(32'h21, 32'h11223344, 2'b10);
    chk("split.b1_addr", maddr[1], 32'h20);
    chk("split.b1_wdata", mwd[1], 32'h22334400);
    chk("split.b1_be", 32'(mbe[1]), 32'hE);
    chk("split.nosplit_err", 32'(er[0]), 32'd1);
    step();
    chk("split.b2_addr", maddr[1], 32'h24);
    chk("split.b2_wdata", mwd[1], 32'h00000011);
    chk("split.b2_be", 32'(mbe[1]), 32'h1);
    chk("split.no_early_done", 32'(dn[1]), 32'd0);
    step();
    chk("split.done", 32'(dn[1]), 32'd1);
    drain();

    // Address wrap with five stalled cycles per beat.
    mem_ready = 1'b0;
    done_cnt  = 0;
    send(32'hFFFFFFFE, 32'hCAFEBABE, 2'b10);
    repeat (5) begin
      chk("wrap.b1_addr", maddr[1], 32'hFFFFFFFC);
      chk("wrap.b1_be", 32'(mbe[1]), 32'hC);
      chk("wrap.b1_wdata", mwd[1], 32'hBABE0000);
      step();
      done_cnt += int'(dn[1]);
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    repeat (5) begin
      chk("wrap.b2_addr", maddr[1], 32'h00000000);
      chk("wrap.b2_be", 32'(mbe[1]), 32'h3);
      chk("wrap.b2_wdata", mwd[1] & 32'h0000FFFF, 32'h0000CAFE);
      step();
      done_cnt += int'(dn[1]);
    end
    mem_ready = 1'b1;
    repeat (3) begin
      step();
      done_cnt += int'(dn[1]);
    end
    chk("wrap.done_count", 32'(done_cnt), 32'd1);

    // Illegal size, then the halfword that only the split instance accepts.
    send(32'h40, 32'h55, 2'b11);
    chk("illegal.err", 32'(er[1]), 32'd1);
    chk("illegal.mem_valid", 32'(mvld[1]), 32'd0);
    drain();
    send(32'h3, 32'h1234, 2'b01);
    chk("half3.nosplit_err", 32'(er[0]), 32'd1);
    chk("half3.nosplit_mem_valid", 32'(mvld[0]), 32'd0);
    chk("half3.split_be", 32'(mbe[1]), 32'h8);
    drain();

    // Reset while the second beat is pending.
    send(32'h21, 32'h11223344, 2'b10);
    step();
    reset = 1'b1;
    step();
    chk("rst_b2.mem_valid", 32'(mvld[1]), 32'd0);
    chk("rst_b2.req_ready", 32'(rdy[1]), 32'd1);
    chk("rst_b2.done", 32'(dn[1]), 32'd0);
    reset = 1'b0;
    step();
    chk("rst_b2.no_late_done", 32'(dn[1]), 32'd0);

    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(63) == 0);
      req_valid = $urandom_range(1);
      mem_ready = ($urandom_range(9) < 6);
      req_addr  = ($urandom_range(7) == 0) ? (32'hFFFFFFF8 | 32'($urandom_range(7))) : $urandom;
      req_data  = $urandom;
      req_size  = 2'($urandom_range(3));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter SPLIT_EN, default 1: 1 = split misaligned stores into two beats; 0 = flag misaligned stores as errors.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, store request present.
REQ-005 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-006 SHALL have port req_addr, input, 32, byte address of the store.
REQ-007 SHALL have port req_data, input, 32, register data, right-justified.
REQ-008 SHALL have port req_size, input, 2, store size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 SHALL have port mem_valid, output, 1, a memory write beat is presented.
REQ-010 SHALL have port mem_ready, input, 1, memory accepts the presented beat.
REQ-011 SHALL have port mem_addr, output, 32, word-aligned beat address; bits [1:0] are always 0.
REQ-012 SHALL have port mem_wdata, output, 32, lane-positioned write data.
REQ-013 SHALL have port mem_be, output, 4, byte enables; bit i enables byte lane i (bits 8i+7:8i), little-endian.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when a store completes.
REQ-015 SHALL have port err, output, 1, one-cycle pulse when a store is rejected.

Function
REQ-016 SHALL implement FSM states IDLE, BEAT1, BEAT2 and ERR; req_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE with req_valid=1 (cycle N), SHALL latch addr, data and size, and SHALL compute off=addr[1:0] and n = 1, 2 or 4 bytes from the size.
REQ-018 If size=11, or if off+n>4 with SPLIT_EN=0, SHALL go to ERR; err=1 in cycle N+1, no mem_valid, then return to IDLE in N+2.
REQ-019 Otherwise SHALL go to BEAT1 with mem_valid=1 from cycle N+1.
REQ-020 The store SHALL be marked two-beat iff off+n>4 (misaligned halfword at off=3; misaligned word at off=1..3).
REQ-021 In BEAT1, mem_addr SHALL be {addr[31:2],00}.
REQ-022 In BEAT1, mem_wdata SHALL be (data << 8*off) truncated to 32 bits.
REQ-023 In BEAT1, mem_be SHALL be bits [3:0] of (M << off), where M is the 8-bit mask 0x01, 0x03 or 0x0F for byte, halfword or word.
REQ-024 For a byte store, data[7:0] SHALL land in lane off and upper data bits SHALL be ignored; a halfword uses data[15:0].
REQ-025 In BEAT2, mem_addr SHALL be {addr[31:2],00}+4 modulo 2^32, wrapping 0xFFFFFFFC to 0x00000000.
REQ-026 In BEAT2, mem_wdata SHALL be data >> 8*(4-off), and mem_be SHALL be bits [7:4] of (M << off).
REQ-027 While mem_valid=1 and mem_ready=0, mem_addr, mem_wdata and mem_be SHALL be held stable for any number of cycles.
REQ-028 On a beat handshake (mem_valid and mem_ready both 1), a two-beat store SHALL move BEAT1->BEAT2, and the final beat SHALL move to IDLE.
REQ-029 done SHALL pulse in the cycle after the final beat handshake; a new request MAY be accepted in that same cycle.
REQ-030 Outside BEAT1/BEAT2, mem_valid, mem_addr, mem_wdata and mem_be SHALL all be 0.
REQ-031 done and err SHALL never be asserted together, and each SHALL be exactly one cycle per store.

Reset
REQ-032 reset=1 at a clock edge SHALL force IDLE and drive req_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0 and err=0 from the next cycle.
REQ-033 A reset mid-store, including between BEAT1 and BEAT2, SHALL abandon the store with no done or err pulse for it.
REQ-034 reset SHALL take priority over a simultaneous req_valid or mem_ready.

Verification
REQ-035 Byte store: addr 0x13, data 0xAABBCCDD -> one beat, addr 0x10, wdata 0xDD000000, be 1000, done pulse.
REQ-036 Halfword store: addr 0x102, data 0x12345678 -> one beat, addr 0x100, wdata 0x56780000, be 1100.
REQ-037 Misaligned word, SPLIT_EN=1: addr 0x21, data 0x11223344 -> beat1 addr 0x20, wdata 0x22334400, be 1110; beat2 addr 0x24, wdata 0x00000011, be 0001; done only after beat2.
REQ-038 Wrap plus backpressure: word store at addr 0xFFFFFFFE, mem_ready low for 5 cycles per beat -> outputs stable throughout; beat2 addr 0x00000000, be 0011; one done pulse.
REQ-039 Errors: size=11 -> err pulse, no mem_valid. SPLIT_EN=0 with halfword at addr 0x3 -> err pulse, no mem_valid.
REQ-040 Reset during BEAT2 -> mem_valid=0 and req_ready=1 next cycle; no done pulse.
